// File: rtl/instr_cache_if.sv
// Fetch, refill and decode-side signals of the instruction cache.
// Signal suffixes are named from the cache's point of view.
interface instr_cache_if #(
    parameter int unsigned PcWidth    = 32,
    parameter int unsigned NumWarps   = 8,
    parameter int unsigned WarpWidth  = 32,
    parameter int unsigned InstrWidth = 32
);
    localparam int unsigned WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1;
    localparam int unsigned SubwarpIdWidth = (WarpWidth > 1) ? $clog2(WarpWidth) : 1;

    // Fetch request from the warp fetcher
    logic                      fe_valid_i;
    logic                      ic_ready_o;
    logic [PcWidth-1:0]        fe_pc_i;
    logic [WarpWidth-1:0]      fe_act_mask_i;
    logic [WidWidth-1:0]       fe_warp_id_i;
    logic [SubwarpIdWidth-1:0] fe_subwarp_id_i;

    // Refill channel to instruction memory
    logic                      mem_req_valid_o;
    logic                      mem_req_ready_i;
    logic [PcWidth-1:0]        mem_req_addr_o;
    logic                      mem_rsp_valid_i;
    logic [InstrWidth-1:0]     mem_rsp_data_i;

    // Instruction delivery to the decoder
    logic                      ic_valid_o;
    logic                      dec_ready_i;
    logic [InstrWidth-1:0]     ic_instr_o;
    logic [PcWidth-1:0]        ic_pc_o;
    logic [WarpWidth-1:0]      ic_act_mask_o;
    logic [WidWidth-1:0]       ic_warp_id_o;
    logic [SubwarpIdWidth-1:0] ic_subwarp_id_o;

    modport slave (
        input  fe_valid_i, fe_pc_i, fe_act_mask_i, fe_warp_id_i, fe_subwarp_id_i,
        output ic_ready_o,
        output mem_req_valid_o, mem_req_addr_o,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        output ic_valid_o, ic_instr_o, ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_subwarp_id_o,
        input  dec_ready_i
    );

    modport master (
        output fe_valid_i, fe_pc_i, fe_act_mask_i, fe_warp_id_i, fe_subwarp_id_i,
        input  ic_ready_o,
        input  mem_req_valid_o, mem_req_addr_o,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  ic_valid_o, ic_instr_o, ic_pc_o, ic_act_mask_o, ic_warp_id_o, ic_subwarp_id_o,
        output dec_ready_i
    );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped blocking instruction cache, one instruction per line.
// Hits deliver one cycle after accept; misses refill from memory with one miss outstanding.
module instr_cache #(
    parameter int unsigned PcWidth    = 32,
    parameter int unsigned NumWarps   = 8,
    parameter int unsigned WarpWidth  = 32,
    parameter int unsigned InstrWidth = 32,
    parameter int unsigned NumLines   = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          flush_i,
    instr_cache_if.slave bus
);
    localparam int unsigned WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1;
    localparam int unsigned SubwarpIdWidth = (WarpWidth > 1) ? $clog2(WarpWidth) : 1;
    localparam int unsigned IdxWidth       = $clog2(NumLines);
    localparam int unsigned TagWidth       = PcWidth - IdxWidth;

    typedef enum logic [1:0] {StIdle, StMissReq, StMissWait} state_e;

    state_e                    state_q, state_d;
    logic                      flush_pend_q, flush_pend_d;

    logic [NumLines-1:0]       valid_q, valid_d;
    logic [TagWidth-1:0]       tag_q  [NumLines];
    logic [TagWidth-1:0]       tag_d  [NumLines];
    logic [InstrWidth-1:0]     data_q [NumLines];
    logic [InstrWidth-1:0]     data_d [NumLines];

    logic [PcWidth-1:0]        pend_pc_q, pend_pc_d;
    logic [WarpWidth-1:0]      pend_mask_q, pend_mask_d;
    logic [WidWidth-1:0]       pend_wid_q, pend_wid_d;
    logic [SubwarpIdWidth-1:0] pend_swid_q, pend_swid_d;

    logic                      out_valid_q, out_valid_d;
    logic [InstrWidth-1:0]     out_instr_q, out_instr_d;
    logic [PcWidth-1:0]        out_pc_q, out_pc_d;
    logic [WarpWidth-1:0]      out_mask_q, out_mask_d;
    logic [WidWidth-1:0]       out_wid_q, out_wid_d;
    logic [SubwarpIdWidth-1:0] out_swid_q, out_swid_d;

    logic                      ic_ready;
    logic                      accept;
    logic                      hit;
    logic                      mem_req_valid;
    logic [IdxWidth-1:0]       req_idx, pend_idx;
    logic [TagWidth-1:0]       req_tag, pend_tag;

    assign req_idx  = bus.fe_pc_i[IdxWidth-1:0];
    assign req_tag  = bus.fe_pc_i[PcWidth-1:IdxWidth];
    assign pend_idx = pend_pc_q[IdxWidth-1:0];
    assign pend_tag = pend_pc_q[PcWidth-1:IdxWidth];

    // Ready only depends on state and the output register draining, never on fe_valid_i
    assign ic_ready = (state_q == StIdle) && (!out_valid_q || bus.dec_ready_i);
    assign accept   = bus.fe_valid_i && ic_ready;
    // A flush in the accept cycle forces a miss
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !flush_i;

    // Next-state logic: lookup, miss sequencing, refill and output register loading
    always_comb begin
        state_d       = state_q;
        flush_pend_d  = flush_pend_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        data_d        = data_q;
        pend_pc_d     = pend_pc_q;
        pend_mask_d   = pend_mask_q;
        pend_wid_d    = pend_wid_q;
        pend_swid_d   = pend_swid_q;
        out_valid_d   = out_valid_q && !bus.dec_ready_i;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        out_mask_d    = out_mask_q;
        out_wid_d     = out_wid_q;
        out_swid_d    = out_swid_q;
        mem_req_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                flush_pend_d = 1'b0;
                if (accept) begin
                    pend_pc_d   = bus.fe_pc_i;
                    pend_mask_d = bus.fe_act_mask_i;
                    pend_wid_d  = bus.fe_warp_id_i;
                    pend_swid_d = bus.fe_subwarp_id_i;
                    if (hit) begin
                        out_valid_d = 1'b1;
                        out_instr_d = data_q[req_idx];
                        out_pc_d    = bus.fe_pc_i;
                        out_mask_d  = bus.fe_act_mask_i;
                        out_wid_d   = bus.fe_warp_id_i;
                        out_swid_d  = bus.fe_subwarp_id_i;
                    end else begin
                        state_d = StMissReq;
                    end
                end
            end
            StMissReq: begin
                mem_req_valid = 1'b1;
                if (flush_i) flush_pend_d = 1'b1;
                if (bus.mem_req_ready_i) state_d = StMissWait;
            end
            StMissWait: begin
                if (flush_i) flush_pend_d = 1'b1;
                if (bus.mem_rsp_valid_i) begin
                    tag_d[pend_idx]  = pend_tag;
                    data_d[pend_idx] = bus.mem_rsp_data_i;
                    // A flush seen during the miss leaves the refilled line invalid
                    if (!flush_pend_q && !flush_i) valid_d[pend_idx] = 1'b1;
                    // Output register is empty here: the accept required it to drain
                    out_valid_d  = 1'b1;
                    out_instr_d  = bus.mem_rsp_data_i;
                    out_pc_d     = pend_pc_q;
                    out_mask_d   = pend_mask_q;
                    out_wid_d    = pend_wid_q;
                    out_swid_d   = pend_swid_q;
                    flush_pend_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) valid_d = '0;
    end

    // Control, metadata and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            pend_pc_q    <= '0;
            pend_mask_q  <= '0;
            pend_wid_q   <= '0;
            pend_swid_q  <= '0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            out_mask_q   <= '0;
            out_wid_q    <= '0;
            out_swid_q   <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            pend_pc_q    <= pend_pc_d;
            pend_mask_q  <= pend_mask_d;
            pend_wid_q   <= pend_wid_d;
            pend_swid_q  <= pend_swid_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_mask_q   <= out_mask_d;
            out_wid_q    <= out_wid_d;
            out_swid_q   <= out_swid_d;
        end
    end

    // Tag/data arrays need no reset; the valid bits guard them
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.ic_ready_o      = ic_ready;
    assign bus.mem_req_valid_o = mem_req_valid;
    assign bus.mem_req_addr_o  = pend_pc_q;
    assign bus.ic_valid_o      = out_valid_q;
    assign bus.ic_instr_o      = out_instr_q;
    assign bus.ic_pc_o         = out_pc_q;
    assign bus.ic_act_mask_o   = out_mask_q;
    assign bus.ic_warp_id_o    = out_wid_q;
    assign bus.ic_subwarp_id_o = out_swid_q;

    a_req_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.mem_req_valid_o && !bus.mem_req_ready_i |=> $stable(bus.mem_req_addr_o));

    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.ic_valid_o && !bus.dec_ready_i |=> bus.ic_valid_o && $stable({bus.ic_instr_o,
        bus.ic_pc_o, bus.ic_act_mask_o, bus.ic_warp_id_o, bus.ic_subwarp_id_o}));

    a_mask_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
        accept |-> bus.fe_act_mask_i != '0);
endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, blocking instruction cache. Responder side of the fetch interface driven by the warp fetcher.
- Accepts one fetch (PC, active mask, warp id, subwarp id) per handshake.
- Looks up the instruction in flop-based tag/data arrays, refills from instruction memory on a miss, and presents the instruction with its fetch metadata to the decoder through a valid/ready output register.

Parameters:
PcWidth, 32, PC width in bits; the PC is an instruction (word) index.
NumWarps, 8, warps per compute unit.
WarpWidth, 32, threads per warp.
InstrWidth, 32, encoded instruction width.
NumLines, 16, cache lines, power of two >= 2; one instruction per line.
Derived, not overridable: WidWidth = max(1, clog2(NumWarps)); SubwarpIdWidth = max(1, clog2(WarpWidth)); IdxWidth = clog2(NumLines); TagWidth = PcWidth - IdxWidth.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  invalidate all lines
fe_valid_i  in  1  fetch request valid
ic_ready_o  out  1  cache can accept a fetch
fe_pc_i  in  PcWidth  fetch PC
fe_act_mask_i  in  WarpWidth  active mask
fe_warp_id_i  in  WidWidth  warp id
fe_subwarp_id_i  in  SubwarpIdWidth  subwarp id
mem_req_valid_o  out  1  refill request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  PcWidth  refill PC
mem_rsp_valid_i  in  1  refill data valid
mem_rsp_data_i  in  InstrWidth  refill instruction
ic_valid_o  out  1  instruction valid to decoder
dec_ready_i  in  1  decoder accepts
ic_instr_o  out  InstrWidth  instruction
ic_pc_o  out  PcWidth  PC of the instruction
ic_act_mask_o  out  WarpWidth  active mask
ic_warp_id_o  out  WidWidth  warp id
ic_subwarp_id_o  out  SubwarpIdWidth  subwarp id

Behaviour:
- Reset (rst_i high at a clock edge):
  - state = IDLE; all valid bits cleared.
  - ic_valid_o = 0, mem_req_valid_o = 0; every data output = 0.
  - Tag/data array contents are don't-care.
- Address split: index = pc[IdxWidth-1:0]; tag = pc[PcWidth-1:IdxWidth].
- ic_ready_o = (state == IDLE) && (!ic_valid_o || dec_ready_i). Purely combinational; must not depend on fe_valid_i.
- Accept = fe_valid_i && ic_ready_o. On accept, the request metadata is captured into the pending register.
- Hit = valid[index] && tag match && !flush_i, evaluated combinationally in the accept cycle.
  - On a hit, the output register loads the instruction and metadata at the same edge.
  - ic_valid_o is therefore high the cycle after accept (latency 1).
  - Back-to-back hits sustain 1 fetch/cycle while dec_ready_i stays high.
- Miss: state goes IDLE -> MISS_REQ at the accept edge.
- MISS_REQ:
  - mem_req_valid_o = 1; mem_req_addr_o = pending PC, held stable until mem_req_ready_i.
  - On handshake -> MISS_WAIT.
- MISS_WAIT:
  - mem_req_valid_o = 0.
  - On mem_rsp_valid_i: write data/tag, set valid[index], load the output register with mem_rsp_data_i plus pending metadata, -> IDLE.
  - mem_rsp_valid_i outside MISS_WAIT is ignored.
- Miss latency: ic_valid_o rises the cycle after mem_rsp_valid_i.
  - The output register is guaranteed empty at that point, because the accept required it to be empty or draining and no other fill happens meanwhile.
- Output register:
  - Holds all ic_* outputs stable while ic_valid_o && !dec_ready_i.
  - Clears ic_valid_o on handshake unless reloaded in the same cycle.
- flush_i:
  - Clears all valid bits at the next edge; does not block ic_ready_o.
  - Flush in the same cycle as an accept forces a miss.
  - Flush during MISS_REQ/MISS_WAIT: the refill still completes and delivers to the decoder, but valid[index] stays 0 if flush_i is high in the fill cycle or was seen after the miss started (sticky flush_pending bit, cleared on return to IDLE).
- Only one miss is outstanding; no fetch is accepted outside IDLE.
- Reset mid-miss: abandon the miss immediately; a later mem_rsp_valid_i is ignored because state is IDLE.
- Assertions:
  - mem_req_addr_o stable while mem_req_valid_o && !mem_req_ready_i.
  - ic_* outputs stable while ic_valid_o && !dec_ready_i.
  - fe_act_mask_i != 0 on accept.

Test Plan:
- Reset, then fetch PC=0x10 (NumLines=16) -> miss; mem_req_addr_o=0x10; memory returns 0xDEADBEEF after 3 cycles -> ic_valid_o the next cycle with ic_instr_o=0xDEADBEEF, ic_pc_o=0x10, and warp id/mask/subwarp echoed.
- Refetch PC=0x10 from warp 3 with mask 0x0000FFFF -> hit; ic_valid_o one cycle after accept; no mem_req_valid_o; ic_warp_id_o=3.
- Fetch PC=0x20 (same index 0, tag 2) after PC=0x10 is cached -> miss and replace; next fetch of 0x10 -> miss again.
- Hold dec_ready_i=0 with a valid output -> ic_ready_o=0 and outputs held 5 cycles; raise dec_ready_i with fe_valid_i high -> handshake plus accept in the same cycle, hit delivered the next cycle.
- Pulse flush_i during MISS_WAIT for PC=0x30 -> instruction still delivered; a subsequent fetch of 0x30 misses.
- Assert rst_i while in MISS_WAIT, then drive mem_rsp_valid_i -> ic_valid_o stays 0, ic_ready_o=1, and a fetch of a previously cached PC misses.
